axi4lite_slave_regs: RTL and testbench
======================================

Name: axi4lite_slave_regs

Overview:
AXI4-Lite responder (slave) that terminates the write and read channels driven by the team's AXI4-Lite master. It exposes a bank of NUM_REGS 32-bit software registers to user logic. Write address and write data are accepted independently, each into a one-deep buffer. Reads are single-outstanding, with registered responses. Out-of-range word indices return SLVERR.

Parameters:
C_S_AXI_DATA_WIDTH, 32, data bus width; fixed at 32.
C_S_AXI_ADDR_WIDTH, 4, byte address width; word index = addr[C_S_AXI_ADDR_WIDTH-1:2].
NUM_REGS, 4, number of implemented registers; 1 to 2^(C_S_AXI_ADDR_WIDTH-2).

Ports:
S_AXI_ACLK  in  1  clock
S_AXI_ARESETN  in  1  reset, asynchronous, active-low
S_AXI_AWADDR  in  C_S_AXI_ADDR_WIDTH  write address
S_AXI_AWPROT  in  3  ignored
S_AXI_AWVALID  in  1  write address valid
S_AXI_AWREADY  out  1  write address ready
S_AXI_WDATA  in  32  write data
S_AXI_WSTRB  in  4  byte strobes
S_AXI_WVALID  in  1  write data valid
S_AXI_WREADY  out  1  write data ready
S_AXI_BRESP  out  2  write response
S_AXI_BVALID  out  1  write response valid
S_AXI_BREADY  in  1  write response ready
S_AXI_ARADDR  in  C_S_AXI_ADDR_WIDTH  read address
S_AXI_ARPROT  in  3  ignored
S_AXI_ARVALID  in  1  read address valid
S_AXI_ARREADY  out  1  read address ready
S_AXI_RDATA  out  32  read data
S_AXI_RRESP  out  2  read response
S_AXI_RVALID  out  1  read data valid
S_AXI_RREADY  in  1  read data ready
USER_REGS  out  NUM_REGS*32  register contents; reg i occupies bits [32i+31:32i]
WR_PULSE  out  NUM_REGS  one-cycle strobe per register on commit

Behaviour:
- Reset (S_AXI_ARESETN low, async):
  - All registers, buffers, USER_REGS, WR_PULSE, BVALID, RVALID, RDATA, BRESP and RRESP clear to 0.
  - AWREADY, WREADY and ARREADY are 0 during reset. They rise at the first clock edge after reset deassertion.
  - Any in-flight transaction is dropped.
- All outputs are registered; no combinational input-to-output path.
- Write address buffer:
  - AWREADY = 1 while the buffer is empty.
  - An AW handshake (AWVALID & AWREADY) latches AWADDR, marks the buffer full and drops AWREADY at the same edge.
- Write data buffer: same scheme for WDATA/WSTRB with WREADY.
- AW and W may arrive in either order or in the same cycle.
- Commit occurs at the first edge where both buffers are full and BVALID = 0. At that edge:
  - If index < NUM_REGS: bytes with WSTRB[b]=1 are updated, WR_PULSE[index]=1 for one cycle, and BRESP=00 (OKAY).
  - Otherwise: no register changes, no pulse, and BRESP=10 (SLVERR).
  - BVALID=1; both buffers are emptied and AWREADY/WREADY return to 1.
- Latency: BVALID rises one cycle after the later of the AW/W handshakes.
- BVALID and BRESP hold until BREADY is sampled high, then BVALID clears at that edge.
- While BVALID=1, at most one further AW and one further W can be buffered. The next commit waits until the edge after the B handshake.
- Read channel:
  - ARREADY = 1 when RVALID = 0 and no read is pending.
  - An AR handshake at edge N loads RDATA (register contents as they stood before edge N) and sets RRESP and RVALID=1 at edge N; ARREADY drops at edge N.
  - RRESP = 00, or 10 with RDATA = 0 for an out-of-range index.
  - RVALID, RDATA and RRESP hold until RREADY=1, then RVALID clears and ARREADY returns to 1 at that edge.
- Simultaneous write commit and AR handshake to the same register at the same edge: the read returns the old value.
- Address bits [1:0] are ignored (no alignment error).
- Read and write paths are fully independent; neither stalls the other.

Test Plan:
- Reset release, then AW addr=0x4 and W data=0xDEADBEEF with strb=0xF in the same cycle -> BVALID 1 cycle later with BRESP=00; USER_REGS[63:32]=0xDEADBEEF; WR_PULSE=0010 for one cycle.
- W data=0x000000AA with strb=0x1 three cycles before AW addr=0x0 (reg0 = 0x12345678) -> WREADY low until commit; reg0=0x123456AA; B 1 cycle after AW.
- Read addr=0x4 after test 1, RREADY held low for 5 cycles -> RVALID and RDATA=0xDEADBEEF stable for all 5 cycles; ARREADY=0 until the R handshake.
- NUM_REGS=3, write and read addr=0xC -> BRESP=10 and RRESP=10 with RDATA=0; registers unchanged; no WR_PULSE.
- BREADY held low, second AW/W issued -> both accepted then READYs low; second commit occurs one cycle after the B handshake.
- Assert ARESETN low mid-transfer with AW buffered and RVALID=1 -> all outputs 0 immediately (asynchronously); after release no stale BVALID or RVALID.

Source files
------------

// File: rtl/axi4lite_slave_regs.sv
// axi4lite_slave_regs: AXI4-Lite responder exposing NUM_REGS 32-bit software registers
// Ports: S_AXI_* AXI4-Lite slave interface (async active-low S_AXI_ARESETN),
//        USER_REGS flattened register contents (reg i at [32i+31:32i]),
//        WR_PULSE one-cycle per-register strobe on each committed write.
module axi4lite_slave_regs #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4,
  parameter int NUM_REGS = 4
) (
  input  logic                                   S_AXI_ACLK,
  input  logic                                   S_AXI_ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]          S_AXI_AWADDR,
  input  logic [2:0]                             S_AXI_AWPROT,
  input  logic                                   S_AXI_AWVALID,
  output logic                                   S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]          S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]        S_AXI_WSTRB,
  input  logic                                   S_AXI_WVALID,
  output logic                                   S_AXI_WREADY,
  output logic [1:0]                             S_AXI_BRESP,
  output logic                                   S_AXI_BVALID,
  input  logic                                   S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]          S_AXI_ARADDR,
  input  logic [2:0]                             S_AXI_ARPROT,
  input  logic                                   S_AXI_ARVALID,
  output logic                                   S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]          S_AXI_RDATA,
  output logic [1:0]                             S_AXI_RRESP,
  output logic                                   S_AXI_RVALID,
  input  logic                                   S_AXI_RREADY,
  output logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] USER_REGS,
  output logic [NUM_REGS-1:0]                    WR_PULSE
);
  localparam int DW = C_S_AXI_DATA_WIDTH;
  localparam int SW = DW / 8;
  localparam int IW = C_S_AXI_ADDR_WIDTH - 2;
  logic [NUM_REGS-1:0][DW-1:0] regs;
  logic aw_full, w_full;
  logic [IW-1:0] aw_idx, ar_idx;
  logic [DW-1:0] w_data, rd_mux;
  logic [SW-1:0] w_strb;
  logic aw_hs, w_hs, ar_hs, commit, aw_ok, ar_ok, unused;
  assign aw_hs = S_AXI_AWVALID & S_AXI_AWREADY;
  assign w_hs = S_AXI_WVALID & S_AXI_WREADY;
  assign ar_hs = S_AXI_ARVALID & S_AXI_ARREADY;
  assign commit = aw_full & w_full & ~S_AXI_BVALID;
  assign ar_idx = S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2];
  assign aw_ok = 32'(aw_idx) < NUM_REGS;
  assign ar_ok = 32'(ar_idx) < NUM_REGS;
  assign USER_REGS = regs;
  assign unused = &{1'b0, S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};
  // out-of-range indices fall through to zero
  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < NUM_REGS; i++)
      if (ar_idx == IW'(i)) rd_mux = regs[i];
  end
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      regs <= '0;
      aw_full <= 1'b0;
      w_full <= 1'b0;
      aw_idx <= '0;
      w_data <= '0;
      w_strb <= '0;
      S_AXI_AWREADY <= 1'b0;
      S_AXI_WREADY <= 1'b0;
      S_AXI_BVALID <= 1'b0;
      S_AXI_BRESP <= 2'b00;
      S_AXI_ARREADY <= 1'b0;
      S_AXI_RVALID <= 1'b0;
      S_AXI_RDATA <= '0;
      S_AXI_RRESP <= 2'b00;
      WR_PULSE <= '0;
    end else begin
      // readies are registered copies of "buffer empty next cycle"
      aw_full <= commit ? 1'b0 : aw_full | aw_hs;
      w_full <= commit ? 1'b0 : w_full | w_hs;
      S_AXI_AWREADY <= commit | ~(aw_full | aw_hs);
      S_AXI_WREADY <= commit | ~(w_full | w_hs);
      if (aw_hs) aw_idx <= S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
      if (w_hs) begin
        w_data <= S_AXI_WDATA;
        w_strb <= S_AXI_WSTRB;
      end
      S_AXI_BVALID <= commit | (S_AXI_BVALID & ~S_AXI_BREADY);
      if (commit) S_AXI_BRESP <= aw_ok ? 2'b00 : 2'b10;
      WR_PULSE <= '0;
      for (int i = 0; i < NUM_REGS; i++)
        if (commit && aw_idx == IW'(i)) begin
          WR_PULSE[i] <= 1'b1;
          for (int b = 0; b < SW; b++)
            if (w_strb[b]) regs[i][8*b +: 8] <= w_data[8*b +: 8];
        end
      S_AXI_RVALID <= ar_hs | (S_AXI_RVALID & ~S_AXI_RREADY);
      S_AXI_ARREADY <= ~(ar_hs | (S_AXI_RVALID & ~S_AXI_RREADY));
      if (ar_hs) begin
        S_AXI_RDATA <= rd_mux;
        S_AXI_RRESP <= ar_ok ? 2'b00 : 2'b10;
      end
    end
  end
endmodule

// File: tb/tb_axi4lite_slave_regs.sv
// tb_axi4lite_slave_regs: table-driven and scoreboard bench for axi4lite_slave_regs (NUM_REGS=3)
module tb_axi4lite_slave_regs;
  logic clk = 1'b0, rst_n;
  logic [3:0] AWADDR, ARADDR;
  logic [2:0] AWPROT, ARPROT;
  logic AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY, ARVALID, ARREADY, RVALID, RREADY;
  logic [31:0] WDATA, RDATA;
  logic [3:0] WSTRB;
  logic [1:0] BRESP, RRESP;
  logic [95:0] USER_REGS;
  logic [2:0] WR_PULSE;
  int vecs = 0, errs = 0;
  logic [1:0] bq[$];
  logic [33:0] rq[$];
  typedef struct packed {
    logic [3:0] waddr;
    logic [31:0] wdata;
    logic [3:0] wstrb;
    logic [1:0] bresp;
    logic [2:0] pulse;
    logic [3:0] raddr;
    logic [1:0] rresp;
    logic [31:0] rdata;
  } vec_t;
  vec_t tbl[6];
  always #5 clk = ~clk;
  axi4lite_slave_regs #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(4), .NUM_REGS(3)) dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
    .S_AXI_AWADDR(AWADDR), .S_AXI_AWPROT(AWPROT), .S_AXI_AWVALID(AWVALID), .S_AXI_AWREADY(AWREADY),
    .S_AXI_WDATA(WDATA), .S_AXI_WSTRB(WSTRB), .S_AXI_WVALID(WVALID), .S_AXI_WREADY(WREADY),
    .S_AXI_BRESP(BRESP), .S_AXI_BVALID(BVALID), .S_AXI_BREADY(BREADY),
    .S_AXI_ARADDR(ARADDR), .S_AXI_ARPROT(ARPROT), .S_AXI_ARVALID(ARVALID), .S_AXI_ARREADY(ARREADY),
    .S_AXI_RDATA(RDATA), .S_AXI_RRESP(RRESP), .S_AXI_RVALID(RVALID), .S_AXI_RREADY(RREADY),
    .USER_REGS(USER_REGS), .WR_PULSE(WR_PULSE)
  );
  task automatic check(input string nm, input logic [95:0] act, input logic [95:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic send_aw(input logic [3:0] a);
    logic go;
    AWADDR = a;
    AWVALID = 1'b1;
    for (int n = 0; n < 20 && AWVALID; n++) begin
      @(negedge clk);
      go = AWREADY;
      tick;
      if (go) AWVALID = 1'b0;
    end
    if (AWVALID) begin
      check("aw_timeout", {95'd0, AWVALID}, 96'd0);
      AWVALID = 1'b0;
    end
  endtask
  task automatic send_w(input logic [31:0] d, input logic [3:0] s);
    logic go;
    WDATA = d;
    WSTRB = s;
    WVALID = 1'b1;
    for (int n = 0; n < 20 && WVALID; n++) begin
      @(negedge clk);
      go = WREADY;
      tick;
      if (go) WVALID = 1'b0;
    end
    if (WVALID) begin
      check("w_timeout", {95'd0, WVALID}, 96'd0);
      WVALID = 1'b0;
    end
  endtask
  task automatic send_ar(input logic [3:0] a);
    logic go;
    ARADDR = a;
    ARVALID = 1'b1;
    for (int n = 0; n < 20 && ARVALID; n++) begin
      @(negedge clk);
      go = ARREADY;
      tick;
      if (go) ARVALID = 1'b0;
    end
    if (ARVALID) begin
      check("ar_timeout", {95'd0, ARVALID}, 96'd0);
      ARVALID = 1'b0;
    end
  endtask
  task automatic do_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s, input logic [1:0] exp);
    bq.push_back(exp);
    fork
      send_aw(a);
      send_w(d, s);
    join
  endtask
  always @(negedge clk) if (rst_n) begin
    if (BVALID && BREADY) begin
      if (bq.size() != 0) check("bresp", {94'd0, BRESP}, {94'd0, bq.pop_front()});
      else check("b_unexpected", {95'd0, BVALID}, 96'd0);
    end
    if (RVALID && RREADY) begin
      if (rq.size() != 0) check("rresp_rdata", {62'd0, RRESP, RDATA}, {62'd0, rq.pop_front()});
      else check("r_unexpected", {95'd0, RVALID}, 96'd0);
    end
  end
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end
  initial begin
    tbl[0] = '{4'h8, 32'hCAFEF00D, 4'hF, 2'b00, 3'b100, 4'h8, 2'b00, 32'hCAFEF00D};
    tbl[1] = '{4'h9, 32'h11223344, 4'hC, 2'b00, 3'b100, 4'hB, 2'b00, 32'h1122F00D};
    tbl[2] = '{4'hC, 32'hFFFFFFFF, 4'hF, 2'b10, 3'b000, 4'hC, 2'b10, 32'h00000000};
    tbl[3] = '{4'h0, 32'h00000000, 4'h0, 2'b00, 3'b001, 4'h0, 2'b00, 32'h123456AA};
    tbl[4] = '{4'hE, 32'h00005555, 4'hF, 2'b10, 3'b000, 4'h4, 2'b00, 32'hDEADBEEF};
    tbl[5] = '{4'h4, 32'hA5A5A5A5, 4'h5, 2'b00, 3'b010, 4'h4, 2'b00, 32'hDEA5BEA5};
    rst_n = 1'b0;
    {AWADDR, ARADDR, AWPROT, ARPROT, WDATA, WSTRB} = '0;
    {AWVALID, WVALID, ARVALID} = '0;
    BREADY = 1'b1;
    RREADY = 1'b1;
    #2;
    check("rst_ready", {93'd0, AWREADY, WREADY, ARREADY}, 96'd0);
    check("rst_valid", {94'd0, BVALID, RVALID}, 96'd0);
    check("rst_regs", USER_REGS, 96'd0);
    check("rst_out", {57'd0, RDATA, RRESP, BRESP, WR_PULSE}, 96'd0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_hold_ready", {93'd0, AWREADY, WREADY, ARREADY}, 96'd0);
    @(negedge clk) rst_n = 1'b1;
    tick;
    check("ready_after_rst", {93'd0, AWREADY, WREADY, ARREADY}, 96'd7);
    // same-cycle AW and W
    bq.push_back(2'b00);
    AWADDR = 4'h4;
    AWVALID = 1'b1;
    WDATA = 32'hDEADBEEF;
    WSTRB = 4'hF;
    WVALID = 1'b1;
    tick;
    AWVALID = 1'b0;
    WVALID = 1'b0;
    check("t1_accepted", {93'd0, AWREADY, WREADY, BVALID}, 96'd0);
    tick;
    check("t1_bvalid", {94'd0, BVALID, 1'b0} | {94'd0, 1'b0, |BRESP}, 96'd2);
    check("t1_reg1", {64'd0, USER_REGS[63:32]}, 96'hDEADBEEF);
    check("t1_pulse", {93'd0, WR_PULSE}, 96'd2);
    tick;
    check("t1_pulse_end", {93'd0, WR_PULSE}, 96'd0);
    check("t1_bdone", {95'd0, BVALID}, 96'd0);
    // W three cycles ahead of AW
    do_write(4'h0, 32'h12345678, 4'hF, 2'b00);
    tick;
    tick;
    bq.push_back(2'b00);
    send_w(32'h000000AA, 4'h1);
    check("t2_wready_low0", {95'd0, WREADY}, 96'd0);
    tick;
    check("t2_wready_low1", {95'd0, WREADY}, 96'd0);
    tick;
    check("t2_wready_low2", {95'd0, WREADY}, 96'd0);
    send_aw(4'h0);
    check("t2_b_not_yet", {95'd0, BVALID}, 96'd0);
    tick;
    check("t2_bvalid", {95'd0, BVALID}, 96'd1);
    check("t2_reg0", {64'd0, USER_REGS[31:0]}, 96'h123456AA);
    check("t2_wready_back", {95'd0, WREADY}, 96'd1);
    tick;
    // read held by RREADY low
    RREADY = 1'b0;
    rq.push_back({2'b00, 32'hDEADBEEF});
    send_ar(4'h4);
    check("t3_r_first", {62'd0, RVALID, ARREADY, RDATA}, {62'd0, 1'b1, 1'b0, 32'hDEADBEEF});
    for (int i = 0; i < 5; i++) begin
      tick;
      check("t3_r_hold", {62'd0, RVALID, ARREADY, RDATA}, {62'd0, 1'b1, 1'b0, 32'hDEADBEEF});
    end
    RREADY = 1'b1;
    tick;
    check("t3_r_done", {94'd0, RVALID, ARREADY}, 96'd1);
    for (int i = 0; i < 6; i++) begin
      do_write(tbl[i].waddr, tbl[i].wdata, tbl[i].wstrb, tbl[i].bresp);
      tick;
      check("tbl_pulse", {93'd0, WR_PULSE}, {93'd0, tbl[i].pulse});
      rq.push_back({tbl[i].rresp, tbl[i].rdata});
      send_ar(tbl[i].raddr);
      tick;
    end
    // AR handshake on the same edge as a commit to the same register sees the old value
    rq.push_back({2'b00, 32'h1122F00D});
    fork
      do_write(4'h8, 32'h0BADCAFE, 4'hF, 2'b00);
      begin
        tick;
        send_ar(4'h8);
      end
    join
    tick;
    tick;
    check("race_reg2", {64'd0, USER_REGS[95:64]}, 96'h0BADCAFE);
    // BREADY stall with a second write buffered
    BREADY = 1'b0;
    do_write(4'h8, 32'h01010101, 4'hF, 2'b00);
    tick;
    check("t5_b1", {95'd0, BVALID}, 96'd1);
    do_write(4'h4, 32'h02020202, 4'hF, 2'b00);
    check("t5_buffered", {93'd0, AWREADY, WREADY, BVALID}, 96'd1);
    tick;
    tick;
    check("t5_no_commit", {64'd0, USER_REGS[63:32]}, 96'hDEA5BEA5);
    check("t5_b_hold", {95'd0, BVALID}, 96'd1);
    BREADY = 1'b1;
    tick;
    check("t5_b_cleared", {95'd0, BVALID}, 96'd0);
    check("t5_still_old", {64'd0, USER_REGS[63:32]}, 96'hDEA5BEA5);
    tick;
    check("t5_b2", {95'd0, BVALID}, 96'd1);
    check("t5_reg1", {64'd0, USER_REGS[63:32]}, 96'h02020202);
    check("t5_pulse", {93'd0, WR_PULSE}, 96'd2);
    for (int n = 0; n < 20 && (bq.size() != 0 || rq.size() != 0); n++) tick;
    check("bq_drained", 96'(bq.size()), 96'd0);
    check("rq_drained", 96'(rq.size()), 96'd0);
    // asynchronous reset mid-transfer
    RREADY = 1'b0;
    send_aw(4'h4);
    send_ar(4'h0);
    check("t6_pre", {94'd0, RVALID, AWREADY}, 96'd2);
    #2 rst_n = 1'b0;
    #1;
    check("t6_async_ready", {93'd0, AWREADY, WREADY, ARREADY}, 96'd0);
    check("t6_async_valid", {94'd0, BVALID, RVALID}, 96'd0);
    check("t6_async_regs", USER_REGS, 96'd0);
    check("t6_async_out", {57'd0, RDATA, RRESP, BRESP, WR_PULSE}, 96'd0);
    @(negedge clk) rst_n = 1'b1;
    RREADY = 1'b1;
    tick;
    check("t6_ready", {93'd0, AWREADY, WREADY, ARREADY}, 96'd7);
    check("t6_no_stale", {94'd0, BVALID, RVALID}, 96'd0);
    send_w(32'h77777777, 4'hF);
    tick;
    tick;
    check("t6_aw_dropped", {95'd0, BVALID}, 96'd0);
    check("t6_regs_zero", USER_REGS, 96'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
